// File: rtl/spi_ctrl_pkg.sv
// Shared constants and types for the SPI master controller:
// command opcodes, request op encodings, FSM state and byte phase.
package spi_ctrl_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h80;
   localparam logic [7:0] CMD_READ  = 8'h08;
   localparam logic [7:0] CMD_CLEAR = 8'h55;

   typedef enum logic [1:0] {
      OP_ILLEGAL = 2'b00,
      OP_WRITE   = 2'b01,
      OP_READ    = 2'b10,
      OP_CLEAR   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      SHIFT   = 3'd2,
      WAIT_WD = 3'd3,
      HOLD    = 3'd4,
      GAP     = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PH_CMD  = 2'd0,
      PH_ADDR = 2'd1,
      PH_DATA = 2'd2
   } phase_e;

   function automatic logic [7:0] cmd_byte(input op_e op);
      case (op)
         OP_WRITE: cmd_byte = CMD_WRITE;
         OP_READ:  cmd_byte = CMD_READ;
         OP_CLEAR: cmd_byte = CMD_CLEAR;
         default:  cmd_byte = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles every CLK_DIV cycles while enabled, idles low, and
// flags the cycle just before each rising/falling edge.
module spi_sclk_gen #(
   parameter int unsigned CLK_DIV = 8
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;
   logic       tick;

   always_comb begin
      tick   = en_i && (cnt_q == DIV_LAST);
      cnt_d  = cnt_q + 8'd1;
      sclk_d = sclk_q;
      if (!en_i) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (tick) begin
         cnt_d  = '0;
         sclk_d = ~sclk_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign rise_o = tick && !sclk_q;
   assign fall_o = tick && sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master (CPOL=0/CPHA=1) issuing command/address/data transactions.
// Handshakes: a transfer happens on a clk_i edge where valid and ready are both high.
module spi_master_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 8,
   parameter int unsigned CS_SETUP = 8,
   parameter int unsigned CS_GAP   = 16
) (
   input  logic       clk_i,
   input  logic       rst_n,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic [1:0] req_op_i,
   input  logic [7:0] req_addr_i,
   input  logic [3:0] req_len_i,
   input  logic [7:0] wdata_i,
   input  logic       wdata_valid_i,
   output logic       wdata_ready_o,
   output logic [7:0] rdata_o,
   output logic       rdata_valid_o,
   output logic       done_o,
   output logic       busy_o,
   output logic       spi_csn_o,
   output logic       spi_clk_o,
   output logic       spi_mosi_o,
   input  logic       spi_miso_i,
   output state_e     dbg_state_o
);

   localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   phase_e      phase_q, phase_d;
   logic [7:0]  addr_q, addr_d, shreg_q, shreg_d, rdata_q, rdata_d;
   logic [6:0]  rx_q, rx_d;
   logic [4:0]  left_q, left_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic        csn_q, csn_d, mosi_q, mosi_d, rvalid_q, rvalid_d, done_q, done_d;
   logic        ready_en_q;
   logic [1:0]  miso_sync_q;
   logic        miso_s, sclk_en, rise, fall;

   assign miso_s = miso_sync_q[1];

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .en_i  (sclk_en),
      .sclk_o(spi_clk_o),
      .rise_o(rise),
      .fall_o(fall)
   );

   always_comb begin
      state_d = state_q;  op_d = op_q;      phase_d = phase_q;  addr_d = addr_q;
      shreg_d = shreg_q;  rdata_d = rdata_q; rx_d = rx_q;       left_d = left_q;
      cnt_d   = cnt_q;    bit_d = bit_q;    csn_d = csn_q;      mosi_d = mosi_q;
      rvalid_d = 1'b0;    done_d = 1'b0;    wdata_ready_o = 1'b0; sclk_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid_i && req_ready_o) begin
               op_d    = op_e'(req_op_i);
               addr_d  = req_addr_i;
               phase_d = PH_CMD;
               bit_d   = '0;
               cnt_d   = '0;
               shreg_d = cmd_byte(op_e'(req_op_i));
               left_d  = (op_e'(req_op_i) == OP_CLEAR) ? 5'd0 : {1'b0, req_len_i} + 5'd2;
               // Illegal op completes immediately without touching the bus.
               if (op_e'(req_op_i) == OP_ILLEGAL) begin
                  done_d  = 1'b1;
                  state_d = GAP;
               end else begin
                  csn_d   = 1'b0;
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sclk_en = 1'b1;
            if (rise) begin
               mosi_d  = shreg_q[7];
               shreg_d = {shreg_q[6:0], 1'b0};
            end
            if (fall) begin
               rx_d  = {rx_q[5:0], miso_s};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  if (phase_q == PH_DATA && op_q == OP_READ) begin
                     rdata_d  = {rx_q, miso_s};
                     rvalid_d = 1'b1;
                  end
                  if (left_q == 5'd0) begin
                     state_d = HOLD;
                     cnt_d   = '0;
                  end else begin
                     left_d  = left_q - 5'd1;
                     phase_d = (phase_q == PH_CMD) ? PH_ADDR : PH_DATA;
                     if (phase_q == PH_CMD) begin
                        shreg_d = addr_q;
                     end else if (op_q == OP_WRITE) begin
                        wdata_ready_o = 1'b1;
                        if (wdata_valid_i) shreg_d = wdata_i;
                        else               state_d = WAIT_WD;
                     end else begin
                        shreg_d = '0;
                     end
                  end
               end
            end
         end
         WAIT_WD: begin
            wdata_ready_o = 1'b1;
            if (wdata_valid_i) begin
               shreg_d = wdata_i;
               state_d = SHIFT;
            end
         end
         HOLD: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               csn_d   = 1'b1;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               state_d = GAP;
            end
         end
         GAP: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;  op_q <= OP_ILLEGAL; phase_q <= PH_CMD; addr_q <= '0;
         shreg_q <= '0;    rdata_q <= '0;      rx_q <= '0;        left_q <= '0;
         cnt_q   <= '0;    bit_q <= '0;        csn_q <= 1'b1;     mosi_q <= 1'b0;
         rvalid_q <= 1'b0; done_q <= 1'b0;     ready_en_q <= 1'b0; miso_sync_q <= '0;
      end else begin
         state_q <= state_d; op_q <= op_d;       phase_q <= phase_d; addr_q <= addr_d;
         shreg_q <= shreg_d; rdata_q <= rdata_d; rx_q <= rx_d;       left_q <= left_d;
         cnt_q   <= cnt_d;   bit_q <= bit_d;     csn_q <= csn_d;     mosi_q <= mosi_d;
         rvalid_q <= rvalid_d; done_q <= done_d; ready_en_q <= 1'b1;
         miso_sync_q <= {miso_sync_q[0], spi_miso_i};
      end
   end

   assign req_ready_o   = ready_en_q && (state_q == IDLE);
   assign busy_o        = (state_q != IDLE);
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rvalid_q;
   assign done_o        = done_q;
   assign spi_csn_o     = csn_q;
   assign spi_mosi_o    = mosi_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with an SPI slave model on the pins.
module tb_spi_master_ctrl;
   import spi_ctrl_pkg::*;

   localparam int CLK_DIV  = 8;
   localparam int CS_SETUP = 8;
   localparam int CS_GAP   = 16;

   logic       clk_i = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid_i = 1'b0;
   logic       req_ready_o;
   logic [1:0] req_op_i = 2'b00;
   logic [7:0] req_addr_i = 8'h00;
   logic [3:0] req_len_i = 4'h0;
   logic [7:0] wdata_i = 8'h00;
   logic       wdata_valid_i = 1'b0;
   logic       wdata_ready_o;
   logic [7:0] rdata_o;
   logic       rdata_valid_o, done_o, busy_o;
   logic       spi_csn_o, spi_clk_o, spi_mosi_o;
   logic       spi_miso_i = 1'b0;
   state_e     dbg_state_o;

   spi_master_ctrl #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
      .clk_i(clk_i), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_addr_i(req_addr_i), .req_len_i(req_len_i),
      .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
      .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .busy_o(busy_o),
      .spi_csn_o(spi_csn_o), .spi_clk_o(spi_clk_o), .spi_mosi_o(spi_mosi_o),
      .spi_miso_i(spi_miso_i), .dbg_state_o(dbg_state_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] mosi_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] wd_q[$];
   logic [7:0] slv_q[$];
   logic       wd_pend = 1'b0;
   logic       prev_sclk = 1'b0, prev_csn = 1'b1, seen_window = 1'b0;
   logic [7:0] mon_byte = 8'h00;
   int mon_bits = 0, slv_ptr = 0, rises = 0, falls = 0, done_cnt = 0;
   int csn_falls = 0, wrdy_cnt = 0, viol = 0, high_run = 0, min_gap = 100000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // write-data driver: presents wd_q[0], pops after each accepted transfer
   always @(negedge clk_i) begin
      if (wd_pend && wd_q.size() > 0) wd_q.delete(0);
      wdata_valid_i = rst_n && (wd_q.size() > 0);
      wdata_i       = (wd_q.size() > 0) ? wd_q[0] : 8'h00;
      wd_pend       = wdata_valid_i && wdata_ready_o;
   end

   // pin monitor and slave model (MISO updated after each SCLK rise)
   always @(negedge clk_i) begin
      if (!rst_n) begin
         prev_sclk = 1'b0;
         prev_csn  = 1'b1;
      end else begin
         if (prev_csn && !spi_csn_o) begin
            csn_falls++;
            mon_bits = 0;
            slv_ptr  = 0;
            if (seen_window && high_run < min_gap) min_gap = high_run;
         end
         if (!prev_csn && spi_csn_o) seen_window = 1'b1;
         if (spi_csn_o) high_run++;
         else           high_run = 0;
         if (spi_clk_o && !prev_sclk) begin
            rises++;
            if (slv_ptr < slv_q.size() * 8) spi_miso_i = slv_q[slv_ptr / 8][7 - (slv_ptr % 8)];
            else                            spi_miso_i = 1'b0;
            slv_ptr++;
         end
         if (!spi_clk_o && prev_sclk) begin
            falls++;
            mon_byte = {mon_byte[6:0], spi_mosi_o};
            mon_bits++;
            if (mon_bits == 8) begin
               mosi_q.push_back(mon_byte);
               mon_bits = 0;
            end
         end
         if (rdata_valid_o) rd_q.push_back(rdata_o);
         if (done_o) done_cnt++;
         if (wdata_ready_o) wrdy_cnt++;
         if (busy_o && req_ready_o) viol++;
         prev_sclk = spi_clk_o;
         prev_csn  = spi_csn_o;
      end
   end

   task automatic clear_mon();
      mosi_q.delete(); rd_q.delete();
      rises = 0; falls = 0; done_cnt = 0; csn_falls = 0; wrdy_cnt = 0; viol = 0;
      min_gap = 100000; seen_window = 1'b0;
   endtask

   task automatic send_req(input logic [1:0] op, input logic [7:0] addr, input logic [3:0] len);
      int n;
      n = 0;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_len_i = len;
      while (!req_ready_o && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      check("req_accept", req_ready_o, 1'b1);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
      n = 0;
      while (busy_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   task automatic check_mosi(input string tag);
      check({tag, "_nbytes"}, mosi_q.size(), exp_q.size());
      foreach (exp_q[i]) check({tag, "_byte"}, (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, exp_q[i]);
   endtask

   initial begin
      int n, bad, r0;
      // reset state
      repeat (3) @(negedge clk_i);
      check("rst_csn", spi_csn_o, 1'b1);
      check("rst_sclk", spi_clk_o, 1'b0);
      check("rst_mosi", spi_mosi_o, 1'b0);
      check("rst_ready", req_ready_o, 1'b0);
      check("rst_wready", wdata_ready_o, 1'b0);
      check("rst_rdata", rdata_o, 8'h00);
      check("rst_rvalid", rdata_valid_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      rst_n = 1'b1;
      @(negedge clk_i);
      check("post_rst_ready", req_ready_o, 1'b1);

      // write 80 10 A5 5A
      clear_mon();
      wd_q = '{8'hA5, 8'h5A};
      send_req(2'b01, 8'h10, 4'd1);
      wait_done("wr");
      exp_q = '{8'h80, 8'h10, 8'hA5, 8'h5A};
      check_mosi("wr");
      check("wr_rises", rises, 32);
      check("wr_csn_windows", csn_falls, 1);
      check("wr_wready_cycles", wrdy_cnt, 2);

      // read 3 bytes from slave returning 11 22 33
      clear_mon();
      slv_q = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
      send_req(2'b10, 8'h20, 4'd2);
      wait_done("rd");
      exp_q = '{8'h08, 8'h20, 8'h00, 8'h00, 8'h00};
      check_mosi("rd");
      check("rd_rises", rises, 40);
      check("rd_nvalid", rd_q.size(), 3);
      exp_q = '{8'h11, 8'h22, 8'h33};
      foreach (exp_q[i]) check("rd_data", (i < rd_q.size()) ? rd_q[i] : 8'hxx, exp_q[i]);
      slv_q.delete();

      // write with second data byte withheld for 100 cycles
      clear_mon();
      wd_q = '{8'hC3};
      send_req(2'b01, 8'h30, 4'd1);
      n = 0;
      while (wd_q.size() != 0 && n < 5000) begin @(negedge clk_i); n++; end
      n = 0;
      @(negedge clk_i);
      while (!wdata_ready_o && n < 5000) begin @(negedge clk_i); n++; end
      check("stall_reached", wdata_ready_o, 1'b1);
      bad = 0;
      r0  = rises;
      repeat (100) begin
         @(negedge clk_i);
         if (spi_clk_o || spi_csn_o) bad++;
      end
      check("stall_pins", bad, 0);
      check("stall_no_edges", rises, r0);
      wd_q.push_back(8'h3C);
      wait_done("stall");
      exp_q = '{8'h80, 8'h30, 8'hC3, 8'h3C};
      check_mosi("stall");
      check("stall_rises", rises, 32);
      check("stall_csn_windows", csn_falls, 1);

      // clear
      clear_mon();
      send_req(2'b11, 8'h77, 4'd5);
      wait_done("clr");
      exp_q = '{8'h55};
      check_mosi("clr");
      check("clr_rises", rises, 8);

      // illegal op: done with no bus activity
      clear_mon();
      send_req(2'b00, 8'h01, 4'd0);
      wait_done("ill");
      check("ill_csn_windows", csn_falls, 0);
      check("ill_rises", rises, 0);

      // reset after 12 SCLK edges of a long write
      clear_mon();
      for (int i = 0; i < 16; i++) wd_q.push_back(8'(i + 1));
      send_req(2'b01, 8'h40, 4'd15);
      n = 0;
      while ((rises + falls) < 12 && n < 5000) begin @(negedge clk_i); n++; end
      check("mid_edges", rises + falls, 12);
      rst_n = 1'b0;
      #1;
      check("mid_rst_csn", spi_csn_o, 1'b1);
      check("mid_rst_sclk", spi_clk_o, 1'b0);
      check("mid_rst_busy", busy_o, 1'b0);
      wd_q.delete();
      repeat (3) @(negedge clk_i);
      check("mid_rst_no_done", done_cnt, 0);
      rst_n = 1'b1;
      clear_mon();
      @(negedge clk_i);
      check("mid_post_ready", req_ready_o, 1'b1);
      send_req(2'b11, 8'h00, 4'd0);
      wait_done("after_rst");
      exp_q = '{8'h55};
      check_mosi("after_rst");

      // back-to-back requests held valid
      clear_mon();
      @(negedge clk_i);
      req_valid_i = 1'b1; req_op_i = 2'b11; req_addr_i = 8'h00; req_len_i = 4'd0;
      n = 0; bad = 0;
      while (bad < 2 && n < 5000) begin
         if (req_ready_o) bad++;
         if (bad < 2) begin @(negedge clk_i); n++; end
      end
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      check("b2b_accepts", bad, 2);
      n = 0;
      while ((done_cnt < 2 || busy_o) && n < 5000) begin @(negedge clk_i); n++; end
      check("b2b_done_cnt", done_cnt, 2);
      check("b2b_windows", csn_falls, 2);
      check("b2b_gap_ok", (min_gap >= CS_GAP) && (min_gap < 100000), 1'b1);
      check("b2b_ready_while_busy", viol, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
